// File: rtl/mu0_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between the MU0 CPU (port 0) and a
// secondary master (port 1). It performs one access at a time and supports RAM read latency 0..7.
module mu0_ram_arbiter #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int RAM_LATENCY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_waitrequest,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_waitrequest,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_read,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   input  logic [DATA_W-1:0] ram_readdata,
   output logic [1:0]        grant,
   output logic              busy
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [2:0] LAT = 3'(RAM_LATENCY);

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        last_q, last_d;
   logic [2:0]  cnt_q, cnt_d;

   logic m0_req, m1_req;
   logic in_access, first_cycle, done;
   logic sel_m1, sel_read, sel_write;

   always_comb begin
      m0_req      = m0_read | m0_write;
      m1_req      = m1_read | m1_write;
      in_access   = (state_q == ACCESS);
      sel_m1      = gnt_q[1];
      // A request with both read and write set is treated as a write.
      sel_write   = sel_m1 ? m1_write : m0_write;
      sel_read    = (sel_m1 ? m1_read : m0_read) & ~sel_write;
      first_cycle = in_access && (cnt_q == LAT);
      done        = in_access && (cnt_q == 3'd0);
   end

   always_comb begin
      ram_address   = '0;
      ram_writedata = '0;
      ram_read      = 1'b0;
      ram_write     = 1'b0;
      if (in_access) begin
         ram_address   = sel_m1 ? m1_address : m0_address;
         ram_writedata = sel_m1 ? m1_writedata : m0_writedata;
         ram_read      = first_cycle & sel_read;
         ram_write     = first_cycle & sel_write;
      end
      // Waitrequest depends only on registered state, never on the request inputs.
      m0_waitrequest = ~(done & gnt_q[0]);
      m1_waitrequest = ~(done & gnt_q[1]);
      m0_readdata    = (done & gnt_q[0] & sel_read) ? ram_readdata : '0;
      m1_readdata    = (done & gnt_q[1] & sel_read) ? ram_readdata : '0;
      grant          = gnt_q;
      busy           = in_access;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               state_d = ACCESS;
               cnt_d   = LAT;
               if (m0_req && m1_req) gnt_d = last_q ? 2'b01 : 2'b10;
               else                  gnt_d = m0_req ? 2'b01 : 2'b10;
            end
         end
         ACCESS: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               state_d = IDLE;
               gnt_d   = 2'b00;
               last_d  = gnt_q[1];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // last_q resets to port 1 so that port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         last_q  <= 1'b1;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
